// File: rtl/poly_eval_pkg.sv
// Shared types and sizing helpers for the Horner polynomial evaluator.
package poly_eval_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} evalState_t;

  localparam int DefaultDataW = 16;
  localparam int DefaultOrder = 4;
  localparam int DefaultOutW  = 32;
  localparam int DefaultIdxW  = $clog2(DefaultOrder + 1);

  function automatic int bytes_per_word(input int dataW);
    return dataW / 8;
  endfunction

endpackage

// File: rtl/poly_horner_eval_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high transition.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prevReg;
  logic pulseReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prevReg  <= 1'b0;
      pulseReg <= 1'b0;
    end else begin
      prevReg  <= level;
      pulseReg <= level & ~prevReg;
    end
  end

  assign rise = pulseReg;

endmodule

// File: rtl/poly_horner_eval.sv
// Byte-loaded coefficient/X registers feeding a one-step-per-clock Horner evaluator
// with busy/ready handshake and a sticky overflow flag.
module poly_horner_eval
  import poly_eval_pkg::*;
#(
  parameter int DATA_W = DefaultDataW,
  parameter int ORDER  = DefaultOrder,
  parameter int OUT_W  = DefaultOutW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 swData,
  input  logic                       GetCoef,
  input  logic                       GetX,
  input  logic                       startEval,
  output logic                       busyEval,
  output logic                       readyEval,
  output logic [OUT_W-1:0]           outEval,
  output logic                       ovfEval,
  output logic [$clog2(ORDER+1)-1:0] coefIdx
);

  localparam int Bytes = bytes_per_word(DATA_W);
  localparam int IdxW  = $clog2(ORDER + 1);
  localparam int CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam int FullW = OUT_W + DATA_W + 1;

  logic coefEv, xEv, startEv;

  rise_detect coefEdge  (.clk(clk), .rst(rst), .level(GetCoef),   .rise(coefEv));
  rise_detect xEdge     (.clk(clk), .rst(rst), .level(GetX),      .rise(xEv));
  rise_detect startEdge (.clk(clk), .rst(rst), .level(startEval), .rise(startEv));

  evalState_t stateReg, stateNext;

  logic [DATA_W-1:0] coefAsmReg, coefAsmNext;
  logic [DATA_W-1:0] xAsmReg, xAsmNext;
  logic [CntW-1:0]   coefCntReg, xCntReg;
  logic [DATA_W-1:0] coefReg [ORDER+1];
  logic [DATA_W-1:0] xReg;
  logic [IdxW-1:0]   idxReg, kReg;
  logic [OUT_W-1:0]  accReg, resultReg;
  logic              ovfReg;

  logic loadOk, coefLoad, xLoad, coefLast, xLast;
  logic [DATA_W-1:0]       coefK;
  logic signed [FullW-1:0] fullSum;
  logic                    fits;

  // Bytes arrive LSB first: each new byte enters at the top and the word shifts right.
  generate
    if (Bytes == 1) begin : gSingleByte
      assign coefAsmNext = swData;
      assign xAsmNext    = swData;
    end else begin : gMultiByte
      assign coefAsmNext = {swData, coefAsmReg[DATA_W-1:8]};
      assign xAsmNext    = {swData, xAsmReg[DATA_W-1:8]};
    end
  endgenerate

  assign loadOk   = (stateReg != RUN);
  assign coefLoad = coefEv & loadOk;
  assign xLoad    = xEv & loadOk;
  assign coefLast = (coefCntReg == CntW'(Bytes - 1));
  assign xLast    = (xCntReg == CntW'(Bytes - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      coefAsmReg <= '0;
      xAsmReg    <= '0;
      coefCntReg <= '0;
      xCntReg    <= '0;
      xReg       <= '0;
      idxReg     <= '0;
      for (int i = 0; i <= ORDER; i++) coefReg[i] <= '0;
    end else begin
      if (coefLoad) begin
        coefAsmReg <= coefAsmNext;
        if (coefLast) begin
          coefReg[idxReg] <= coefAsmNext;
          coefCntReg      <= '0;
          idxReg          <= (idxReg == IdxW'(ORDER)) ? '0 : idxReg + 1'b1;
        end else begin
          coefCntReg <= coefCntReg + 1'b1;
        end
      end
      if (xLoad) begin
        xAsmReg <= xAsmNext;
        if (xLast) begin
          xReg    <= xAsmNext;
          xCntReg <= '0;
        end else begin
          xCntReg <= xCntReg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (startEv) stateNext = RUN;
      RUN:  if (kReg == '0) stateNext = DONE;
      DONE: begin
        if (startEv)            stateNext = RUN;
        else if (coefEv || xEv) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Full-precision multiply-add; the product of the sign-extended operands always fits FullW.
  assign coefK   = coefReg[kReg];
  assign fullSum = FullW'($signed(accReg)) * FullW'($signed(xReg)) + FullW'($signed(coefK));
  assign fits    = (&fullSum[FullW-1:OUT_W-1]) | ~(|fullSum[FullW-1:OUT_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      accReg    <= '0;
      kReg      <= '0;
      ovfReg    <= 1'b0;
      resultReg <= '0;
    end else if (stateReg == RUN) begin
      accReg <= fullSum[OUT_W-1:0];
      if (!fits) ovfReg <= 1'b1;
      if (kReg == '0) resultReg <= fullSum[OUT_W-1:0];
      else            kReg      <= kReg - 1'b1;
    end else if (startEv) begin
      accReg <= OUT_W'($signed(coefReg[ORDER]));
      kReg   <= IdxW'(ORDER - 1);
      ovfReg <= 1'b0;
    end
  end

  assign busyEval  = (stateReg == RUN);
  assign readyEval = (stateReg == DONE);
  assign outEval   = resultReg;
  assign ovfEval   = ovfReg;
  assign coefIdx   = idxReg;

endmodule
